world_time_set: RTL and testbench
=================================

Name: world_time_set

Overview:
- Inverse of the KST-to-zone hour display path: the user enters a wall-clock time in a selected zone, and the block converts it back to KST.
- It presents the result to the KST timekeeper through a valid/ack load handshake.
- It sits between the button debouncers, the timekeeper and the display mux.
- Zone map, fixed: 0 = KST (UTC+9), 1 = UTC+1, 2 = UTC-5, 3 = UTC.

Parameters:
- TIMEOUT_CYCLES, 32'd50_000_000: idle cycles in an edit state before auto-abort.
- HOLD_CNT_W, 26: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tz_sel  input  2  zone select; sampled only on set_req
- set_req  input  1  single-cycle pulse to start an edit
- hour_inc  input  1  single-cycle pulse: edit hour +1
- hour_dec  input  1  single-cycle pulse: edit hour -1
- min_inc  input  1  single-cycle pulse: edit minute +1
- next  input  1  single-cycle pulse: advance HOUR->MIN, or MIN->commit
- cancel  input  1  single-cycle pulse: abort edit
- cur_hour_kst  input  5  current KST hour, 0..23
- cur_min  input  6  current minute, 0..59
- load_ack  input  1  timekeeper accepted the load
- edit_hour  output  5  local-zone hour being edited
- edit_min  output  6  minute being edited
- edit_tz  output  2  latched zone
- busy  output  1  high in any non-IDLE state
- state_o  output  3  state encoding, for display blink
- load_valid  output  1  load request to the timekeeper
- load_hour_kst  output  5  converted KST hour
- load_min  output  6  minute to load

Behaviour:
- Reset (async assert, sync deassert by clk): state IDLE; every output 0, including edit_tz and state_o.
- Clock and reset ports are one clock, clk, with reset rst_n asynchronous and active-low.
- States: IDLE=0, EDIT_HOUR=1, EDIT_MIN=2, CONVERT=3, LOAD=4.
- IDLE, on set_req:
  - latch edit_tz <= tz_sel.
  - edit_hour <= cur_hour_kst converted to the zone: offsets +0, -8, -14, -9 mod 24.
  - edit_min <= cur_min.
  - next state EDIT_HOUR.
- EDIT_HOUR:
  - hour_inc wraps 23->0; hour_dec wraps 0->23.
  - If hour_inc and hour_dec arrive in the same cycle, no change.
  - next -> EDIT_MIN.
- EDIT_MIN:
  - min_inc wraps 59->0; the hour is not touched.
  - next -> CONVERT.
- CONVERT (exactly 1 cycle):
  - load_hour_kst = (edit_hour + K) mod 24, with K = 0, 8, 14, 9 for tz 0..3.
  - Computed in a 6-bit intermediate, one conditional subtract of 24.
  - load_min <= edit_min.
  - next -> LOAD.
- LOAD:
  - load_valid = 1; load_hour_kst and load_min are held stable while valid.
  - On the cycle load_ack=1, load_valid deasserts next cycle and the state returns to IDLE.
  - Latency from the final next pulse to the first load_valid cycle is 2 clocks.
- cancel:
  - In EDIT_HOUR or EDIT_MIN, returns to IDLE next cycle with no load.
  - Ignored in CONVERT and LOAD; a load, once started, completes.
- Timeout:
  - The counter clears on entry to an edit state and on any hour_inc/hour_dec/min_inc/next.
  - When it reaches TIMEOUT_CYCLES-1, the block acts as cancel.
  - The counter is inactive outside the edit states.
- set_req outside IDLE is ignored; tz_sel changes during an edit are ignored.
- Cancel has priority over next in the same cycle; next has priority over inc/dec.
- rst_n low mid-operation: immediate return to IDLE with load_valid=0; no partial load.
- edit_hour and edit_min are never outside 0..23 and 0..59.

Optional Feature:
- Macro: WTS_DAY_ROLL_EN.
- Defined:
  - Adds output day_inc (1 bit), registered with load_hour_kst.
  - day_inc = 1 when edit_hour + K >= 24, i.e. the KST date is the next day relative to the local date.
  - Valid while load_valid=1; 0 otherwise and at reset.
- Undefined: port absent; no related logic.

Test Plan:
- tz=2, cur KST 10:15, set_req: edit_hour=20. Then next, 15x min_inc, next: edit_min=30; load_hour_kst=10, load_min=30, load_valid 2 clocks after next; day_inc=1 when enabled.
- tz=1, edit hour set to 15, ack held high: load_hour_kst=23, day_inc=0; load_valid exactly 1 cycle.
- Wrap: edit_hour=23 + hour_inc -> 0; edit_hour=0 + hour_dec -> 23; edit_min=59 + min_inc -> 0 with hour unchanged; inc+dec in the same cycle -> unchanged.
- Load with load_ack low for 5 cycles: load_valid and data stable all 5 cycles; IDLE one cycle after ack.
- Edit aborts, all with no load_valid and busy=0 afterwards:
  - cancel in EDIT_MIN -> IDLE next cycle.
  - With TIMEOUT_CYCLES=8, 8 idle cycles in EDIT_HOUR -> IDLE.
  - cancel and next in the same cycle -> IDLE.
- rst_n pulsed low during LOAD: outputs 0 asynchronously, state IDLE. A new set_req after release works normally with tz=3: KST 00 -> edit_hour 15.

Source files
------------

// File: rtl/world_time_set_if.sv
// Load handshake between world_time_set (master) and the KST timekeeper (slave).
// Optional macro WTS_DAY_ROLL_EN adds the day_inc flag alongside the load data.
interface world_time_set_if;
    logic       load_valid;
    logic       load_ack;
    logic [4:0] load_hour_kst;
    logic [5:0] load_min;
`ifdef WTS_DAY_ROLL_EN
    logic       day_inc;
`endif

`ifdef WTS_DAY_ROLL_EN
    modport master (output load_valid, load_hour_kst, load_min, day_inc, input load_ack);
    modport slave  (input load_valid, load_hour_kst, load_min, day_inc, output load_ack);
`else
    modport master (output load_valid, load_hour_kst, load_min, input load_ack);
    modport slave  (input load_valid, load_hour_kst, load_min, output load_ack);
`endif
endinterface

// File: rtl/world_time_set.sv
// world_time_set: edit a wall-clock time in a selected zone and hand it back
// to the KST timekeeper as a valid/ack load.
// Zones: 0 = KST (UTC+9), 1 = UTC+1, 2 = UTC-5, 3 = UTC.
// Optional macro WTS_DAY_ROLL_EN adds day_inc on the load interface.
module world_time_set #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int unsigned HOLD_CNT_W     = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       tz_sel,
    input  logic             set_req,
    input  logic             hour_inc,
    input  logic             hour_dec,
    input  logic             min_inc,
    input  logic             next,
    input  logic             cancel,
    input  logic [4:0]       cur_hour_kst,
    input  logic [5:0]       cur_min,
    output logic [4:0]       edit_hour,
    output logic [5:0]       edit_min,
    output logic [1:0]       edit_tz,
    output logic             busy,
    output logic [2:0]       state_o,
    world_time_set_if.master load_bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        CONVERT   = 3'd3,
        LOAD      = 3'd4
    } state_t;

    localparam logic [HOLD_CNT_W-1:0] TIMEOUT_LAST = HOLD_CNT_W'(TIMEOUT_CYCLES - 32'd1);

    state_t                  state;
    state_t                  state_nx;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [4:0]              load_hour_q;
    logic [5:0]              load_min_q;

    logic                    in_edit;
    logic                    activity;
    logic                    timeout;
    logic                    abort;

    logic [5:0]              local_sum;
    logic [4:0]              local_hour;
    logic [5:0]              kst_sum;
    logic [4:0]              kst_hour;

    // KST -> zone is done as an addition of (24 - offset) to stay unsigned.
    function automatic logic [5:0] local_add(input logic [1:0] tz);
        case (tz)
            2'd0:    return 6'd0;
            2'd1:    return 6'd16;
            2'd2:    return 6'd10;
            default: return 6'd15;
        endcase
    endfunction

    function automatic logic [5:0] kst_add(input logic [1:0] tz);
        case (tz)
            2'd0:    return 6'd0;
            2'd1:    return 6'd8;
            2'd2:    return 6'd14;
            default: return 6'd9;
        endcase
    endfunction

    assign in_edit  = (state == EDIT_HOUR) || (state == EDIT_MIN);
    assign activity = hour_inc | hour_dec | min_inc | next;
    assign timeout  = in_edit && (hold_cnt == TIMEOUT_LAST);
    assign abort    = in_edit && (cancel || timeout);

    assign local_sum  = {1'b0, cur_hour_kst} + local_add(tz_sel);
    assign local_hour = (local_sum >= 6'd24) ? 5'(local_sum - 6'd24) : local_sum[4:0];
    assign kst_sum    = {1'b0, edit_hour} + kst_add(edit_tz);
    assign kst_hour   = (kst_sum >= 6'd24) ? 5'(kst_sum - 6'd24) : kst_sum[4:0];

    assign load_bus.load_hour_kst = load_hour_q;
    assign load_bus.load_min      = load_min_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and state-decoded outputs; abort (cancel/timeout) beats next
    always_comb begin
        state_nx            = state;
        busy                = (state != IDLE);
        state_o             = state;
        load_bus.load_valid = 1'b0;
        case (state)
            IDLE: begin
                if (set_req) state_nx = EDIT_HOUR;
            end
            EDIT_HOUR: begin
                if (abort)     state_nx = IDLE;
                else if (next) state_nx = EDIT_MIN;
            end
            EDIT_MIN: begin
                if (abort)     state_nx = IDLE;
                else if (next) state_nx = CONVERT;
            end
            CONVERT: begin
                state_nx = LOAD;
            end
            LOAD: begin
                load_bus.load_valid = 1'b1;
                if (load_bus.load_ack) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Inactivity counter: cleared on state change, user activity, or outside edit states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!in_edit || activity || (state_nx != state)) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
        end
    end

    // Edit registers and load data; load data only changes in CONVERT so it is stable during LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edit_hour   <= '0;
            edit_min    <= '0;
            edit_tz     <= '0;
            load_hour_q <= '0;
            load_min_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (set_req) begin
                        edit_tz   <= tz_sel;
                        edit_hour <= local_hour;
                        edit_min  <= cur_min;
                    end
                end
                EDIT_HOUR: begin
                    if (!abort && !next) begin
                        if (hour_inc && !hour_dec)
                            edit_hour <= (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
                        else if (hour_dec && !hour_inc)
                            edit_hour <= (edit_hour == 5'd0) ? 5'd23 : edit_hour - 5'd1;
                    end
                end
                EDIT_MIN: begin
                    if (!abort && !next && min_inc)
                        edit_min <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
                end
                CONVERT: begin
                    load_hour_q <= kst_hour;
                    load_min_q  <= edit_min;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef WTS_DAY_ROLL_EN
    logic day_inc_q;

    assign load_bus.day_inc = day_inc_q;

    // Day roll flag: set with the load data, dropped when the load is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_inc_q <= 1'b0;
        end else if (state == CONVERT) begin
            day_inc_q <= (kst_sum >= 6'd24);
        end else if ((state == LOAD) && load_bus.load_ack) begin
            day_inc_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_world_time_set.sv
// Bench for world_time_set: directed edits; a monitor checks every load
// presented by the DUT against a queue of expected loads.
module tb_world_time_set;

    localparam logic [5:0] P_SET  = 6'b100000;
    localparam logic [5:0] P_HINC = 6'b010000;
    localparam logic [5:0] P_HDEC = 6'b001000;
    localparam logic [5:0] P_MIN  = 6'b000100;
    localparam logic [5:0] P_NEXT = 6'b000010;
    localparam logic [5:0] P_CAN  = 6'b000001;

    typedef struct {
        logic [4:0] hour;
        logic [5:0] min;
        logic       day;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] tz_sel;
    logic       set_req, hour_inc, hour_dec, min_inc, next, cancel;
    logic [4:0] cur_hour_kst;
    logic [5:0] cur_min;
    logic [4:0] edit_hour;
    logic [5:0] edit_min;
    logic [1:0] edit_tz;
    logic       busy;
    logic [2:0] state_o;

    world_time_set_if lif();

    world_time_set #(.TIMEOUT_CYCLES(32'd8), .HOLD_CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tz_sel       (tz_sel),
        .set_req      (set_req),
        .hour_inc     (hour_inc),
        .hour_dec     (hour_dec),
        .min_inc      (min_inc),
        .next         (next),
        .cancel       (cancel),
        .cur_hour_kst (cur_hour_kst),
        .cur_min      (cur_min),
        .edit_hour    (edit_hour),
        .edit_min     (edit_min),
        .edit_tz      (edit_tz),
        .busy         (busy),
        .state_o      (state_o),
        .load_bus     (lif)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t cur_exp;
    logic have_exp   = 1'b0;
    logic prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic [5:0] p);
        {set_req, hour_inc, hour_dec, min_inc, next, cancel} = p;
        @(negedge clk);
        {set_req, hour_inc, hour_dec, min_inc, next, cancel} = '0;
    endtask

    task automatic push(input int h, input int m, input int d);
        exp_t e;
        e.hour = 5'(h);
        e.min  = 6'(m);
        e.day  = d[0];
        exp_q.push_back(e);
    endtask

    // Monitor: every load_valid cycle is compared against the expected load
    always @(negedge clk) begin
        if (rst_n && lif.load_valid) begin
            if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    have_exp = 1'b0;
                    $display("FAIL unexpected_load: got hour %0d min %0d expected no load",
                             lif.load_hour_kst, lif.load_min);
                end else begin
                    cur_exp  = exp_q.pop_front();
                    have_exp = 1'b1;
                end
            end
            if (have_exp) begin
                chk("load_hour_kst", int'(lif.load_hour_kst), int'(cur_exp.hour));
                chk("load_min", int'(lif.load_min), int'(cur_exp.min));
`ifdef WTS_DAY_ROLL_EN
                chk("day_inc", int'(lif.day_inc), int'(cur_exp.day));
`endif
            end
        end
        prev_valid = lif.load_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tz_sel = '0;
        {set_req, hour_inc, hour_dec, min_inc, next, cancel} = '0;
        cur_hour_kst = '0;
        cur_min = '0;
        lif.load_ack = 1'b0;
        cyc(2);
        chk("rst_edit_hour", int'(edit_hour), 0);
        chk("rst_edit_min", int'(edit_min), 0);
        chk("rst_edit_tz", int'(edit_tz), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_valid", int'(lif.load_valid), 0);
        chk("rst_load_hour", int'(lif.load_hour_kst), 0);
        chk("rst_load_min", int'(lif.load_min), 0);
        rst_n = 1'b1;
        cyc(1);

        // tz=2, KST 10:15 -> local 20:15, minutes to 30, back to KST 10:30 next day
        tz_sel = 2'd2; cur_hour_kst = 5'd10; cur_min = 6'd15;
        step(P_SET);
        tz_sel = 2'd0;
        chk("t1_edit_hour", int'(edit_hour), 20);
        chk("t1_edit_min", int'(edit_min), 15);
        chk("t1_edit_tz", int'(edit_tz), 2);
        chk("t1_state_hour", int'(state_o), 1);
        chk("t1_busy", int'(busy), 1);
        step(P_NEXT);
        chk("t1_state_min", int'(state_o), 2);
        for (int i = 0; i < 15; i++) begin
            step(P_MIN);
            step('0);
        end
        chk("t1_edit_min30", int'(edit_min), 30);
        chk("t1_hour_kept", int'(edit_hour), 20);
        push(10, 30, 1);
        step(P_NEXT);
        chk("t1_convert_state", int'(state_o), 3);
        chk("t1_convert_novalid", int'(lif.load_valid), 0);
        cyc(1);
        chk("t1_valid_2clk", int'(lif.load_valid), 1);
        chk("t1_load_state", int'(state_o), 4);
        lif.load_ack = 1'b1;
        cyc(1);
        lif.load_ack = 1'b0;
        chk("t1_valid_drop", int'(lif.load_valid), 0);
        chk("t1_idle", int'(state_o), 0);
        chk("t1_busy_low", int'(busy), 0);
`ifdef WTS_DAY_ROLL_EN
        chk("t1_day_cleared", int'(lif.day_inc), 0);
`endif

        // tz=1, KST 03:40 -> local 19, dec to 15, ack held high -> KST 23:40, one valid cycle
        tz_sel = 2'd1; cur_hour_kst = 5'd3; cur_min = 6'd40;
        step(P_SET);
        chk("t2_edit_hour", int'(edit_hour), 19);
        for (int i = 0; i < 4; i++) step(P_HDEC);
        chk("t2_edit_hour15", int'(edit_hour), 15);
        lif.load_ack = 1'b1;
        push(23, 40, 0);
        step(P_NEXT);
        step(P_NEXT);
        chk("t2_convert_novalid", int'(lif.load_valid), 0);
        cyc(1);
        chk("t2_valid", int'(lif.load_valid), 1);
        cyc(1);
        chk("t2_valid_one_cycle", int'(lif.load_valid), 0);
        chk("t2_idle", int'(state_o), 0);
        lif.load_ack = 1'b0;

        // Wraps, simultaneous inc/dec, then a load held for 5 cycles with ack low
        tz_sel = 2'd0; cur_hour_kst = 5'd23; cur_min = 6'd59;
        step(P_SET);
        chk("t3_edit_hour23", int'(edit_hour), 23);
        step(P_HINC);
        chk("t3_hour_wrap_up", int'(edit_hour), 0);
        step(P_HDEC);
        chk("t3_hour_wrap_dn", int'(edit_hour), 23);
        step(P_HINC | P_HDEC);
        chk("t3_incdec_same", int'(edit_hour), 23);
        step(P_NEXT);
        step(P_MIN);
        chk("t3_min_wrap", int'(edit_min), 0);
        chk("t3_min_wrap_hour", int'(edit_hour), 23);
        push(23, 0, 0);
        step(P_NEXT);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t3_valid_held", int'(lif.load_valid), 1);
            chk("t3_hour_stable", int'(lif.load_hour_kst), 23);
            chk("t3_min_stable", int'(lif.load_min), 0);
        end
        lif.load_ack = 1'b1;
        cyc(1);
        lif.load_ack = 1'b0;
        chk("t3_valid_drop", int'(lif.load_valid), 0);
        chk("t3_idle", int'(state_o), 0);

        // Cancel in EDIT_MIN
        tz_sel = 2'd0; cur_hour_kst = 5'd5; cur_min = 6'd5;
        step(P_SET);
        step(P_NEXT);
        chk("t4_in_min", int'(state_o), 2);
        step(P_CAN);
        chk("t4_cancel_idle", int'(state_o), 0);
        chk("t4_cancel_busy", int'(busy), 0);
        cyc(3);
        chk("t4_no_load", int'(lif.load_valid), 0);

        // Timeout in EDIT_HOUR after 8 idle cycles
        step(P_SET);
        cyc(7);
        chk("t5_still_edit", int'(state_o), 1);
        cyc(1);
        chk("t5_timeout_idle", int'(state_o), 0);
        chk("t5_timeout_busy", int'(busy), 0);
        cyc(3);
        chk("t5_no_load", int'(lif.load_valid), 0);

        // Cancel wins over next
        step(P_SET);
        step(P_NEXT | P_CAN);
        chk("t6_cancel_next_idle", int'(state_o), 0);
        chk("t6_busy", int'(busy), 0);
        cyc(3);
        chk("t6_no_load", int'(lif.load_valid), 0);

        // Reset during LOAD, then a fresh edit with tz=3
        tz_sel = 2'd0; cur_hour_kst = 5'd12; cur_min = 6'd34;
        step(P_SET);
        push(12, 34, 0);
        step(P_NEXT);
        step(P_NEXT);
        cyc(1);
        chk("t7_valid_before_rst", int'(lif.load_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", int'(lif.load_valid), 0);
        chk("t7_rst_state", int'(state_o), 0);
        chk("t7_rst_busy", int'(busy), 0);
        chk("t7_rst_load_hour", int'(lif.load_hour_kst), 0);
        chk("t7_rst_load_min", int'(lif.load_min), 0);
        chk("t7_rst_edit_hour", int'(edit_hour), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tz_sel = 2'd3; cur_hour_kst = 5'd0; cur_min = 6'd0;
        step(P_SET);
        chk("t7_edit_hour15", int'(edit_hour), 15);
        chk("t7_edit_tz3", int'(edit_tz), 3);
        lif.load_ack = 1'b1;
        push(0, 0, 1);
        step(P_NEXT);
        step(P_NEXT);
        cyc(1);
        chk("t7_valid", int'(lif.load_valid), 1);
        cyc(1);
        chk("t7_valid_drop", int'(lif.load_valid), 0);
        lif.load_ack = 1'b0;

        cyc(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
